// File: rtl/ram_stream_reader_if.sv
// Request, BRAM port-B and output-stream signals of ram_stream_reader.
// The master modport is the reader itself; the slave modport is its environment.
interface ram_stream_reader_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned READ_WIDTH = 64
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;
    logic                  read_error;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [READ_WIDTH-1:0] doutb;
    logic [READ_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        input  start, start_addr, length, doutb, dout_ready,
        output busy, done, read_error, enb, addrb, dout, dout_valid
    );

    modport slave (
        output start, start_addr, length, doutb, dout_ready,
        input  busy, done, read_error, enb, addrb, dout, dout_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader for BRAM port B: issues wrapped reads, tracks the fixed read latency and
// streams returned words through a small credit-managed buffer onto a valid/ready output.
module ram_stream_reader #(
    parameter int unsigned BRAM_READ_LATENCY = 2,
    parameter int unsigned READ_WIDTH        = 64,
    parameter int unsigned TOTAL_SIZE        = 64 * 128
) (
    input logic                 bram_clk,
    input logic                 reset,
    ram_stream_reader_if.master bus
);
    // DEPTH must be a power of two and BRAM_READ_LATENCY at least 1.
    localparam int unsigned DEPTH      = TOTAL_SIZE / READ_WIDTH;
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned BUF_DEPTH  = BRAM_READ_LATENCY + 2;
    localparam int unsigned PTR_WIDTH  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_WIDTH  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned L          = BRAM_READ_LATENCY;

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [L-1:0]          vpipe_q, vpipe_d;
    logic [READ_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  inflight;
    logic                  done_q, read_error_q;
    logic                  busy, issue, accept, last_issue, drained;
    logic                  push, pop, dout_valid;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(L); i++) begin
            inflight = inflight + CNT_WIDTH'(vpipe_q[i]);
        end
    end

    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = issue;
        for (int i = 1; i < int'(L); i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    assign push       = vpipe_q[L-1];
    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid && bus.dout_ready;
    assign accept     = bus.start && (state_q == StIdle) && (bus.length != '0);
    assign last_issue = issue && (remaining_q == LEN_WIDTH'(1));
    // Nothing left in the BRAM pipe and the buffer empties with this cycle's handshake.
    assign drained    = (inflight == '0) && ((count_q - CNT_WIDTH'(pop)) == '0);

    always_ff @(posedge bram_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  if (last_issue) state_d = StDrain;
            StDrain: if (drained) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Credit check uses registered counts only; a same-cycle pop does not free a slot.
    always_comb begin
        busy  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            StIdle: ;
            StRead: begin
                busy  = 1'b1;
                issue = (inflight + count_q) < CNT_WIDTH'(BUF_DEPTH);
            end
            StDrain: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge bram_clk) begin
        if (reset) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            vpipe_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= bus.start_addr;
                remaining_q <= bus.length;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
            vpipe_q <= vpipe_d;
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q      <= count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            done_q       <= (state_q == StDrain) && drained;
            read_error_q <= bus.start && ((bus.length == '0) || (state_q != StIdle));
        end
    end

    always_ff @(posedge bram_clk) begin
        if (push) buf_mem[wr_ptr_q] <= bus.doutb;
    end

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.read_error = read_error_q;
    assign bus.enb        = issue;
    assign bus.addrb      = addr_q;
    assign bus.dout_valid = dout_valid;
    assign bus.dout       = dout_valid ? buf_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: behavioural BRAM, per-feature scenario tasks
// and an address/data model computed directly from the burst rules.
module tb_ram_stream_reader;
    localparam int L     = 2;
    localparam int W     = 64;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int LW    = 8;
    localparam int BUFD  = L + 2;

    logic bram_clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 bram_clk = ~bram_clk;

    ram_stream_reader_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_WIDTH(W)) bus ();

    ram_stream_reader #(
        .BRAM_READ_LATENCY(L),
        .READ_WIDTH       (W),
        .TOTAL_SIZE       (W * DEPTH)
    ) dut (
        .bram_clk(bram_clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Behavioural BRAM port B with a fixed read latency of L cycles.
    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] rd_pipe [L];
    always @(posedge bram_clk) begin
        for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.enb) rd_pipe[0] <= mem[bus.addrb];
    end
    assign bus.doutb = rd_pipe[L-1];

    logic [W-1:0]  got   [$];
    logic [AW-1:0] addrs [$];
    int            err_cnt, err_cyc, hold_viol, done_cyc, first_dv_cyc, enb_at_stall;
    logic          dv_at_stall;
    logic [W-1:0]  dout_at_stall;

    task automatic tick();
        @(posedge bram_clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_word(input logic [AW-1:0] a, input int i);
        return mem[(int'(a) + i) % DEPTH];
    endfunction

    function automatic int stream_mismatch(input logic [AW-1:0] a, input int n);
        if (got.size() != n) return -2;
        for (int i = 0; i < n; i++) if (got[i] !== model_word(a, i)) return i;
        return -1;
    endfunction

    function automatic int addr_mismatch(input logic [AW-1:0] a, input int n);
        if (addrs.size() != n) return -2;
        for (int i = 0; i < n; i++) if (addrs[i] !== AW'((int'(a) + i) % DEPTH)) return i;
        return -1;
    endfunction

    // Runs one burst starting in cycle 0 and records what the DUT does until done.
    task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] n, input int pct,
                             input int stall, input int bad_cyc);
        logic         prev_stall;
        logic [W-1:0] prev_dout;
        got.delete();
        addrs.delete();
        err_cnt = 0; err_cyc = -1; hold_viol = 0; done_cyc = -1; first_dv_cyc = -1;
        enb_at_stall = -1; dv_at_stall = 1'b0; dout_at_stall = '0;
        prev_stall = 1'b0; prev_dout = '0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            bus.start      = (c == 0) || (c == bad_cyc);
            bus.start_addr = (c == 0) ? a : a + AW'(37);
            bus.length     = (c == 0) ? n : LW'(3);
            bus.dout_ready = (c >= stall) && (int'($urandom_range(99)) < pct);
            @(negedge bram_clk);
            if (prev_stall && (!bus.dout_valid || bus.dout !== prev_dout)) hold_viol++;
            if (bus.enb) addrs.push_back(bus.addrb);
            if (bus.dout_valid && first_dv_cyc < 0) first_dv_cyc = c;
            if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
            if (bus.read_error) begin err_cnt++; err_cyc = c; end
            if (c == stall - 1) begin
                enb_at_stall  = addrs.size();
                dv_at_stall   = bus.dout_valid;
                dout_at_stall = bus.dout;
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_dout  = bus.dout;
            if (bus.done) begin done_cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.dout_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge bram_clk);
        checks++;
        if ({bus.busy, bus.done, bus.read_error, bus.enb, bus.dout_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got busy/done/err/enb/dv=%b want 00000",
                     {bus.busy, bus.done, bus.read_error, bus.enb, bus.dout_valid});
        end
        checks++;
        if (bus.addrb !== '0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_bus got addrb=%0d dout=%h want 0/0", bus.addrb, bus.dout);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic         en_exp, dv_exp;
        logic [W-1:0] d_exp;
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.start = (c == 0); bus.start_addr = AW'(5); bus.length = LW'(4);
            bus.dout_ready = 1'b1;
            @(negedge bram_clk);
            en_exp = (c >= 1) && (c <= 4);
            checks++;
            if (bus.enb !== en_exp || (en_exp && bus.addrb !== AW'(4 + c))) begin
                errors++;
                $display("FAIL basic_enb cyc=%0d got enb=%b addrb=%0d want enb=%b addrb=%0d",
                         c, bus.enb, bus.addrb, en_exp, 4 + c);
            end
            dv_exp = (c >= L + 2) && (c < L + 6);
            d_exp  = dv_exp ? W'(c - (L + 2) + 5) : '0;
            checks++;
            if (bus.dout_valid !== dv_exp || bus.dout !== d_exp) begin
                errors++;
                $display("FAIL basic_dout cyc=%0d got dv=%b dout=%0d want dv=%b dout=%0d",
                         c, bus.dout_valid, bus.dout, dv_exp, d_exp);
            end
            checks++;
            if (bus.done !== (c == L + 6)) begin
                errors++;
                $display("FAIL basic_done cyc=%0d got %b want %b", c, bus.done, c == L + 6);
            end
            checks++;
            if (bus.busy !== (c >= 1 && c < L + 6)) begin
                errors++;
                $display("FAIL basic_busy cyc=%0d got %b want %b", c, bus.busy,
                         c >= 1 && c < L + 6);
            end
        end
    endtask

    task automatic test_wrap();
        int m;
        run_burst(AW'(126), LW'(4), 100, 0, -1);
        m = addr_mismatch(AW'(126), 4);
        checks++;
        if (m != -1) begin
            errors++;
            $display("FAIL wrap_addr idx=%0d got %0d addrs want 126,127,0,1", m, addrs.size());
        end
        m = stream_mismatch(AW'(126), 4);
        checks++;
        if (m != -1) begin
            errors++;
            $display("FAIL wrap_data idx=%0d got %0d words want 4 in order", m, got.size());
        end
        checks++;
        if (done_cyc != 4 + L + 2) begin
            errors++;
            $display("FAIL wrap_done got cycle %0d want %0d", done_cyc, 4 + L + 2);
        end
        run_burst(AW'(10), LW'(200), 60, 0, -1);
        m = stream_mismatch(AW'(10), 200);
        checks++;
        if (m != -1 || err_cnt != 0 || done_cyc < 0) begin
            errors++;
            $display("FAIL wrap_long idx=%0d words=%0d errs=%0d done=%0d want -1/200/0/seen",
                     m, got.size(), err_cnt, done_cyc);
        end
        m = addr_mismatch(AW'(10), 200);
        checks++;
        if (m != -1) begin
            errors++;
            $display("FAIL wrap_long_addr idx=%0d got %0d issues want 200", m, addrs.size());
        end
    endtask

    task automatic test_backpressure();
        int m;
        run_burst(AW'(50), LW'(10), 50, 12, -1);
        checks++;
        if (enb_at_stall != BUFD) begin
            errors++;
            $display("FAIL bp_credit got %0d issues while stalled want %0d", enb_at_stall, BUFD);
        end
        checks++;
        if (dv_at_stall !== 1'b1 || dout_at_stall !== mem[50]) begin
            errors++;
            $display("FAIL bp_head got dv=%b dout=%h want dv=1 dout=%h",
                     dv_at_stall, dout_at_stall, mem[50]);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d stall violations want 0", hold_viol);
        end
        m = stream_mismatch(AW'(50), 10);
        checks++;
        if (m != -1 || done_cyc < 0) begin
            errors++;
            $display("FAIL bp_data idx=%0d words=%0d done=%0d want all 10 in order",
                     m, got.size(), done_cyc);
        end
    endtask

    task automatic test_errors();
        int m;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.start = (c == 0); bus.start_addr = AW'(3); bus.length = '0;
            bus.dout_ready = 1'b1;
            @(negedge bram_clk);
            checks++;
            if (bus.read_error !== (c == 1) || bus.enb !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL err_len0 cyc=%0d got err=%b enb=%b busy=%b want %b/0/0",
                         c, bus.read_error, bus.enb, bus.busy, c == 1);
            end
        end
        run_burst(AW'(20), LW'(12), 100, 0, 3);
        checks++;
        if (err_cnt != 1 || err_cyc != 4) begin
            errors++;
            $display("FAIL err_busy got %0d pulses last at %0d want 1 at 4", err_cnt, err_cyc);
        end
        m = stream_mismatch(AW'(20), 12);
        checks++;
        if (m != -1 || done_cyc != 12 + L + 2) begin
            errors++;
            $display("FAIL err_burst idx=%0d words=%0d done=%0d want -1/12/%0d",
                     m, got.size(), done_cyc, 12 + L + 2);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.start = (c == 0); bus.start_addr = AW'(20); bus.length = LW'(8);
            bus.dout_ready = 1'b1;
            reset = (c == 3);
            @(negedge bram_clk);
            if (c >= 4) begin
                checks++;
                if ({bus.busy, bus.done, bus.read_error, bus.enb, bus.dout_valid} !== 5'b0 ||
                    bus.addrb !== '0 || bus.dout !== '0) begin
                    errors++;
                    $display("FAIL rst_mid cyc=%0d got flags=%b addrb=%0d dout=%h want zeros",
                             c, {bus.busy, bus.done, bus.read_error, bus.enb, bus.dout_valid},
                             bus.addrb, bus.dout);
                end
            end
        end
        run_burst(AW'(0), LW'(1), 100, 0, -1);
        checks++;
        if (got.size() != 1 || got[0] !== mem[0] || first_dv_cyc != L + 2) begin
            errors++;
            $display("FAIL rst_restart got words=%0d first_dv=%0d want 1 word %h at %0d",
                     got.size(), first_dv_cyc, mem[0], L + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a, b;
        int            n, k, d, errs_seen, b_first_enb, b_done, bad;
        logic          done_ok;
        logic [W-1:0]  exp_q [$];
        a = AW'(100); b = AW'(120); n = 6; k = 5;
        d = n + L + 2;
        got.delete();
        errs_seen = 0; b_first_enb = -1; b_done = -1; done_ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            bus.start      = (c == 0) || (c == d);
            bus.start_addr = (c == 0) ? a : b;
            bus.length     = (c == 0) ? LW'(n) : LW'(k);
            bus.dout_ready = 1'b1;
            @(negedge bram_clk);
            if (c == d) done_ok = bus.done;
            if (c > d && bus.enb && b_first_enb < 0) b_first_enb = c;
            if (bus.read_error) errs_seen++;
            if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
            if (c > d && bus.done) begin b_done = c; break; end
        end
        for (int i = 0; i < n; i++) exp_q.push_back(model_word(a, i));
        for (int i = 0; i < k; i++) exp_q.push_back(model_word(b, i));
        checks++;
        if (done_ok !== 1'b1 || b_first_enb != d + 1 || errs_seen != 0) begin
            errors++;
            $display("FAIL b2b_accept got done=%b first_enb=%0d errs=%0d want 1/%0d/0",
                     done_ok, b_first_enb, errs_seen, d + 1);
        end
        bad = (got.size() != exp_q.size()) ? -2 : -1;
        for (int i = 0; i < got.size() && bad == -1; i++) if (got[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad != -1 || b_done != d + k + L + 2) begin
            errors++;
            $display("FAIL b2b_stream idx=%0d words=%0d done=%0d want -1/%0d/%0d",
                     bad, got.size(), b_done, n + k, d + k + L + 2);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int            n, pct, m, ma;
        for (int t = 0; t < 6; t++) begin
            a   = AW'($urandom_range(DEPTH - 1));
            n   = int'($urandom_range(60, 1));
            pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 30);
            run_burst(a, LW'(n), pct, 0, -1);
            m  = stream_mismatch(a, n);
            ma = addr_mismatch(a, n);
            checks++;
            if (m != -1 || ma != -1 || hold_viol != 0 || err_cnt != 0 || done_cyc < 0) begin
                errors++;
                $display("FAIL rand t=%0d a=%0d n=%0d got data_idx=%0d addr_idx=%0d hold=%0d errs=%0d done=%0d want -1/-1/0/0/seen",
                         t, a, n, m, ma, hold_viol, err_cnt, done_cyc);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), $urandom()};
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

- Drains stored words from the port-B side of the team's BRAM buffer and streams them out over a valid/ready interface.
- A controller requests a burst with `start`, `start_addr` and `length`. The block then issues `enb`/`addrb` reads with address wrap-around and tracks the fixed BRAM read latency.
- Returned data lands in a small credit-managed output buffer, so downstream backpressure never loses a word.
- The block sits on `bram_clk`, opposite the FIFO-fed port-A write path.

## Interface
Parameters:
- `BRAM_READ_LATENCY`, 2: cycles from `enb` sample to valid `doutb`; minimum 1.
- `READ_WIDTH`, 64: data width in bits.
- `TOTAL_SIZE`, 64*128: memory size in bits. DEPTH = TOTAL_SIZE/READ_WIDTH, and DEPTH must be a power of two.
- Derived localparams:
  - ADDR_WIDTH = $clog2(DEPTH)
  - LEN_WIDTH = ADDR_WIDTH+1
  - BUF_DEPTH = BRAM_READ_LATENCY+2

Ports:
- `bram_clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle burst request.
- `start_addr` in ADDR_WIDTH: first word address.
- `length` in LEN_WIDTH: number of words; 0 is illegal.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst completion.
- `read_error` out 1: one-cycle pulse when a request is rejected.
- `enb` out 1: BRAM port-B read enable.
- `addrb` out ADDR_WIDTH: BRAM port-B address.
- `doutb` in READ_WIDTH: BRAM port-B read data.
- `dout` out READ_WIDTH: stream data.
- `dout_valid` out 1: stream valid.
- `dout_ready` in 1: stream ready.

## Operation
- **States:** IDLE, READ, DRAIN. `busy` is 1 in READ and DRAIN.
- **IDLE:** a `start` with `length`≠0 captures `start_addr` into the address counter and `length` into `remaining`, then goes to READ.
- **READ:** `enb`=1 in any cycle where `inflight + count < BUF_DEPTH`, using registered values with no same-cycle pop credit.
  - Each issue decrements `remaining`.
  - Each issue advances `addrb` by 1, with DEPTH-1 → 0 wrap.
  - Go to DRAIN on the cycle the last read issues.
- **DRAIN:** wait until `inflight`=0 and the buffer is empty after a handshake, then go to IDLE and pulse `done`.
- **Latency tracking:** a BRAM_READ_LATENCY-bit valid shift register takes `enb`. When its MSB is set, `doutb` is written into the buffer. `inflight` equals the popcount of the shift register.
- **Output buffer:** a BUF_DEPTH-entry FIFO; overflow is impossible by construction.
  - `dout_valid` = buffer non-empty.
  - `dout` = head entry; it is driven 0 when `dout_valid`=0.
  - A pop occurs on `dout_valid && dout_ready`.
- **Rejected requests:** `read_error` pulses the cycle after `start` when any of these holds; the request is ignored and any running burst is unaffected:
  - `length`=0;
  - `start` while `busy`.
- **Long bursts:** `length` > DEPTH is legal; addresses keep wrapping.
- **Back-to-back:** `start` in the `done` cycle is accepted, because the state is already IDLE.
- **Reset mid-burst:**
  - State goes to IDLE; counters, the valid pipe and the buffer are cleared.
  - Data already in flight in the BRAM is discarded and never appears on `dout`.

## Timing
- **Reset values:** `busy`, `done`, `read_error`, `enb`, `dout_valid` = 0; `addrb`, `dout` = 0.
- **Cycle numbering:** `start` is sampled in cycle 0.
  - The first `enb` is in cycle 1.
  - An `enb` in cycle T gives `doutb` valid in cycle T+L (L = BRAM_READ_LATENCY), buffered at the end of T+L, and `dout_valid` in T+L+1.
- **First word:** `dout_valid` in cycle L+2; cycle 4 at the defaults.
- **Throughput:** one word per cycle sustained while `dout_ready`=1 (steady state `inflight`=L, `count`=1).
- **Completion:** the last handshake in cycle X gives `done`=1 and `busy`=0 in X+1.
- **Stream rule:** while `dout_valid`=1 and `dout_ready`=0, `dout` is held stable. `dout_valid` never deasserts without a handshake except on reset.
- **Registered outputs:** `read_error` and `done` are registered, one cycle each.

## Test plan
- **Basic burst:** memory word i holds i; `start_addr`=5, `length`=4, `dout_ready`=1.
  - `enb` in cycles 1–4 with `addrb` 5,6,7,8.
  - `dout_valid` in cycles 4–7 with data 5,6,7,8.
  - `done` in cycle 8.
- **Wrap:** `start_addr`=126, `length`=4 → `addrb` 126,127,0,1; data order preserved; `length`=200 wraps twice without error.
- **Backpressure:** `dout_ready`=0 from cycle 0, `length`=10.
  - `enb` stops after exactly 4 issues; `dout` is held at the first word.
  - Toggle `dout_ready` randomly → all 10 words are delivered in order, none duplicated or dropped.
- **Errors:**
  - `length`=0 → `read_error` in cycle 1, no `enb`, `busy` stays 0.
  - `start` mid-burst → `read_error` pulse; the running burst completes unchanged.
- **Reset mid-burst:** `length`=8, `reset` in cycle 3.
  - From cycle 4 all outputs are 0.
  - No `dout_valid` appears from the 3 in-flight reads.
  - A new `start` (`start_addr`=0, `length`=1) then returns word 0 in cycle L+2 after it.
- **Back-to-back:** second `start` asserted in the `done` cycle is accepted; its first `enb` follows one cycle later, with no `read_error`.
